// File: rtl/debounce_sync.sv
// Multi-bit switch debouncer: synchronizer chain, then a two-state FSM that commits a
// candidate word only after it has been stable for DEBOUNCE_CYCLES consecutive cycles.
module debounce_sync #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed,
  output logic             stable
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE, COUNT} state_e;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_chain_q;
  logic [WIDTH-1:0]                  sync_q;

  state_e           state_q,   state_d;
  logic [WIDTH-1:0] cand_q,    cand_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [WIDTH-1:0] dout_q,    dout_d;
  logic [WIDTH-1:0] rise_q,    rise_d;
  logic [WIDTH-1:0] fall_q,    fall_d;
  logic             changed_q, changed_d;

  // din feeds the first flop directly; no logic ahead of the synchronizer
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_chain_q <= '0;
    end else begin
      sync_chain_q[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_chain_q[i] <= sync_chain_q[i-1];
    end
  end

  assign sync_q = sync_chain_q[SYNC_STAGES-1];

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    dout_d    = dout_q;
    rise_d    = '0;
    fall_d    = '0;
    changed_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync_q != dout_q) begin
          cand_d  = sync_q;
          cnt_d   = '0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (sync_q == dout_q) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (sync_q != cand_q) begin
          // any further bit movement restarts the whole word
          cand_d = sync_q;
          cnt_d  = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          dout_d    = cand_q;
          rise_d    = cand_q & ~dout_q;
          fall_d    = ~cand_q & dout_q;
          changed_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cand_q    <= '0;
      cnt_q     <= '0;
      dout_q    <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      dout_q    <= dout_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

  assign dout    = dout_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign changed = changed_q;
  assign stable  = (state_q == IDLE);

endmodule

// File: tb/tb_debounce_sync.sv
// Scoreboard bench for debounce_sync: stimulus pushes expected commits (edge, dout, rise,
// fall); a monitor pops one on every changed pulse and flags any pulse outside a commit.
module tb_debounce_sync;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic [7:0] dout, rise, fall;
  logic       changed, stable;

  int edge_cnt = 0;
  int pass_cnt = 0;
  int tot_cnt  = 0;

  typedef struct {
    int         e;
    logic [7:0] d;
    logic [7:0] r;
    logic [7:0] f;
  } exp_t;
  exp_t sb[$];

  debounce_sync #(.WIDTH(8), .DEBOUNCE_CYCLES(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .din(din), .dout(dout), .rise(rise),
    .fall(fall), .changed(changed), .stable(stable)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s @edge %0d: got %0h expected %0h", name, edge_cnt, act, exp);
  endtask

  // value first sampled by the DUT at posedge k
  task automatic drive_at(input int k, input logic [7:0] v);
    while (edge_cnt < k - 1) @(negedge clk);
    din = v;
  endtask

  task automatic rst_at(input int k, input logic v);
    while (edge_cnt < k - 1) @(negedge clk);
    rst = v;
  endtask

  // look at outputs in the cycle following posedge k
  task automatic at_edge(input int k);
    while (edge_cnt < k) @(negedge clk);
  endtask

  task automatic expect_commit(input int e, input logic [7:0] d, input logic [7:0] r,
                               input logic [7:0] f);
    exp_t x;
    x.e = e; x.d = d; x.r = r; x.f = f;
    sb.push_back(x);
  endtask

  // monitor
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (changed === 1'b1) begin
        if (sb.size() == 0) begin
          tot_cnt++;
          $display("FAIL unexpected_commit @edge %0d: dout=%0h rise=%0h fall=%0h",
                   edge_cnt, dout, rise, fall);
        end else begin
          x = sb.pop_front();
          check("commit_edge", edge_cnt, x.e);
          check("commit_dout", dout, x.d);
          check("commit_rise", rise, x.r);
          check("commit_fall", fall, x.f);
        end
      end else if (edge_cnt > 1) begin
        check("no_pulse", {rise, fall}, 16'h0000);
      end
    end
  end

  initial begin
    // reset state
    at_edge(2);
    check("rst_dout", dout, 8'h00);
    check("rst_changed", changed, 1'b0);
    check("rst_stable", stable, 1'b1);
    rst_at(4, 1'b0);

    // clean rise 00 -> A5
    expect_commit(28, 8'hA5, 8'hA5, 8'h00);
    drive_at(10, 8'hA5);
    at_edge(11); check("clean_stable_pre", stable, 1'b1);
    at_edge(12); check("clean_stable_lo0", stable, 1'b0);
    at_edge(27); check("clean_stable_lo1", stable, 1'b0);
    check("clean_dout_hold", dout, 8'h00);
    at_edge(28); check("clean_stable_post", stable, 1'b1);

    // back to zero
    expect_commit(53, 8'h00, 8'h00, 8'hA5);
    drive_at(35, 8'h00);

    // bounce: toggles every 3 cycles, never stable long enough
    for (int i = 0; i < 10; i++)
      drive_at(60 + 3 * i, (i % 2 == 0) ? 8'h01 : 8'h00);
    at_edge(90); check("bounce_stable_lo", stable, 1'b1);
    at_edge(95);
    check("bounce_dout", dout, 8'h00);
    check("bounce_stable", stable, 1'b1);

    // restart: 0F then FF five cycles later; one commit to FF
    expect_commit(123, 8'hFF, 8'hFF, 8'h00);
    drive_at(100, 8'h0F);
    drive_at(105, 8'hFF);
    at_edge(110); check("restart_stable", stable, 1'b0);
    at_edge(122); check("restart_dout_hold", dout, 8'h00);

    // falling commit FF -> 3C
    expect_commit(148, 8'h3C, 8'h00, 8'hC3);
    drive_at(130, 8'h3C);

    // reset eight cycles into COUNT toward AA
    drive_at(155, 8'hAA);
    rst_at(165, 1'b1);
    rst_at(166, 1'b0);
    at_edge(165);
    check("midrst_dout", dout, 8'h00);
    check("midrst_stable", stable, 1'b1);
    check("midrst_changed", changed, 1'b0);
    expect_commit(184, 8'hAA, 8'hAA, 8'h00);
    at_edge(183); check("midrst_dout_hold", dout, 8'h00);

    at_edge(200);
    check("sb_drained", sb.size(), 0);
    check("final_dout", dout, 8'hAA);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
